// File: rtl/cache_mem_sequencer_pkg.sv
// Shared bus-2 definitions for the cache<->memory line sequencer:
// bus widths, C2 command encoding, request opcodes and sequencer states.
package cache_bus2_pkg;

    localparam int unsigned CACHE_LINE_SIZE = 16;
    localparam int unsigned DATA_BUS_SIZE   = 16;
    localparam int unsigned ADDR2_BUS_SIZE  = 14;
    localparam int unsigned CTR2_BUS_SIZE   = 2;
    localparam int unsigned LINE_BITS       = CACHE_LINE_SIZE * 8;
    localparam int unsigned BEATS           = LINE_BITS / DATA_BUS_SIZE;
    localparam int unsigned BEAT_CNT_W      = $clog2(BEATS);

    typedef enum logic [CTR2_BUS_SIZE-1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_cmd_t;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_WB      = 2'b01,
        OP_FILL    = 2'b10,
        OP_WB_FILL = 2'b11
    } req_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_SEND,
        S_WB_WAIT,
        S_TURN,
        S_RD_CMD,
        S_RD_WAIT,
        S_RD_RECV,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/cache_mem_sequencer_if.sv
// Cache-core request/completion signals plus bus-2 drive/sample signals.
// slave = sequencer side, master = core + memory side.
interface cache_mem_sequencer_if;
    import cache_bus2_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic [1:0]                req_op;
    logic [ADDR2_BUS_SIZE-1:0] req_wb_addr;
    logic [ADDR2_BUS_SIZE-1:0] req_fill_addr;
    logic [LINE_BITS-1:0]      req_wb_line;
    logic [LINE_BITS-1:0]      fill_line;
    logic                      done;
    logic                      done_err;
    logic [CTR2_BUS_SIZE-1:0]  c2_in;
    logic [CTR2_BUS_SIZE-1:0]  c2_out;
    logic                      c2_oe;
    logic [ADDR2_BUS_SIZE-1:0] a2_out;
    logic                      a2_oe;
    logic [DATA_BUS_SIZE-1:0]  d2_in;
    logic [DATA_BUS_SIZE-1:0]  d2_out;
    logic                      d2_oe;

    modport slave (
        input  req_valid, req_op, req_wb_addr, req_fill_addr, req_wb_line, c2_in, d2_in,
        output req_ready, fill_line, done, done_err, c2_out, c2_oe, a2_out, a2_oe, d2_out, d2_oe
    );

    modport master (
        output req_valid, req_op, req_wb_addr, req_fill_addr, req_wb_line, c2_in, d2_in,
        input  req_ready, fill_line, done, done_err, c2_out, c2_oe, a2_out, a2_oe, d2_out, d2_oe
    );

endinterface

// File: rtl/cache_mem_sequencer_line_beat_buffer.sv
// 8x16-bit line shift buffer: parallel load / beat-out for write-back,
// beat-in / parallel read for fill, with a wrapping beat counter.
module line_beat_buffer
    import cache_bus2_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     load,
    input  logic [LINE_BITS-1:0]     line_in,
    input  logic                     clr,
    input  logic                     shift_out,
    input  logic                     shift_in,
    input  logic [DATA_BUS_SIZE-1:0] beat_in,
    output logic [DATA_BUS_SIZE-1:0] beat_out,
    output logic [LINE_BITS-1:0]     line_out,
    output logic [BEAT_CNT_W-1:0]    beat_cnt
);

    logic [LINE_BITS-1:0] line_q;

    // Beat 0 lives in the low slot; both directions shift towards it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            line_q   <= '0;
            beat_cnt <= '0;
        end else if (load) begin
            line_q   <= line_in;
            beat_cnt <= '0;
        end else if (clr) begin
            beat_cnt <= '0;
        end else if (shift_out) begin
            line_q   <= {{DATA_BUS_SIZE{1'b0}}, line_q[LINE_BITS-1:DATA_BUS_SIZE]};
            beat_cnt <= beat_cnt + 1'b1;
        end else if (shift_in) begin
            line_q   <= {beat_in, line_q[LINE_BITS-1:DATA_BUS_SIZE]};
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    assign beat_out = line_q[DATA_BUS_SIZE-1:0];
    assign line_out = line_q;

endmodule

// File: rtl/cache_mem_sequencer.sv
// Sequences cache line write-backs and fills over bus 2, owning the bus
// drive enables, the turnaround cycle and the memory response watchdog.
module cache_mem_sequencer
    import cache_bus2_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  RESET,
    cache_mem_sequencer_if.slave  bus
);

    localparam int unsigned WD_W = $clog2(MEM_TIMEOUT + 1);

    seq_state_t                state;
    logic [1:0]                op_q;
    logic [ADDR2_BUS_SIZE-1:0] fill_addr_q;
    logic [WD_W-1:0]           wd_cnt;

    logic                      resp;
    logic                      accept;
    logic                      wd_expired;
    logic                      last_beat;
    logic                      buf_clr;
    logic                      buf_shift_out;
    logic                      buf_shift_in;
    logic [BEAT_CNT_W-1:0]     beat_cnt;
    logic [LINE_BITS-1:0]      buf_line;
    logic [DATA_BUS_SIZE-1:0]  buf_beat;

    always_comb begin
        resp          = (bus.c2_in == C2_RESPONSE);
        accept        = (state == S_IDLE) && bus.req_valid && (bus.req_op != OP_NONE);
        wd_expired    = (wd_cnt == WD_W'(MEM_TIMEOUT - 1));
        last_beat     = (beat_cnt == BEAT_CNT_W'(BEATS - 1));
        buf_clr       = (state == S_RD_CMD);
        buf_shift_out = (state == S_WB_SEND);
        buf_shift_in  = resp && ((state == S_RD_WAIT) || (state == S_RD_RECV));
    end

    line_beat_buffer u_buf (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (accept),
        .line_in   (bus.req_wb_line),
        .clr       (buf_clr),
        .shift_out (buf_shift_out),
        .shift_in  (buf_shift_in),
        .beat_in   (bus.d2_in),
        .beat_out  (buf_beat),
        .line_out  (buf_line),
        .beat_cnt  (beat_cnt)
    );

    assign bus.req_ready = (state == S_IDLE);
    assign bus.d2_out    = buf_beat;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= S_IDLE;
            op_q          <= '0;
            fill_addr_q   <= '0;
            wd_cnt        <= '0;
            bus.c2_out    <= C2_NOP;
            bus.a2_out    <= '0;
            bus.c2_oe     <= 1'b0;
            bus.a2_oe     <= 1'b0;
            bus.d2_oe     <= 1'b0;
            bus.done      <= 1'b0;
            bus.done_err  <= 1'b0;
            bus.fill_line <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.done_err <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    op_q        <= bus.req_op;
                    fill_addr_q <= bus.req_fill_addr;
                    bus.c2_oe   <= 1'b1;
                    bus.a2_oe   <= 1'b1;
                    if (bus.req_op[0]) begin
                        state      <= S_WB_SEND;
                        bus.c2_out <= C2_WRITE_LINE;
                        bus.a2_out <= bus.req_wb_addr;
                        bus.d2_oe  <= 1'b1;
                    end else begin
                        state      <= S_RD_CMD;
                        bus.c2_out <= C2_READ_LINE;
                        bus.a2_out <= bus.req_fill_addr;
                    end
                end
                S_WB_SEND: if (last_beat) begin
                    state      <= S_WB_WAIT;
                    wd_cnt     <= '0;
                    bus.c2_out <= C2_NOP;
                    bus.c2_oe  <= 1'b0;
                    bus.a2_oe  <= 1'b0;
                    bus.d2_oe  <= 1'b0;
                end
                S_WB_WAIT: begin
                    if (resp) begin
                        if (op_q[1]) begin
                            state <= S_TURN;
                        end else begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        state        <= S_DONE;
                        bus.done     <= 1'b1;
                        bus.done_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_TURN: begin
                    state      <= S_RD_CMD;
                    bus.c2_out <= C2_READ_LINE;
                    bus.a2_out <= fill_addr_q;
                    bus.c2_oe  <= 1'b1;
                    bus.a2_oe  <= 1'b1;
                end
                S_RD_CMD: begin
                    state      <= S_RD_WAIT;
                    wd_cnt     <= '0;
                    bus.c2_out <= C2_NOP;
                    bus.c2_oe  <= 1'b0;
                    bus.a2_oe  <= 1'b0;
                end
                S_RD_WAIT: begin
                    if (resp) begin
                        state <= S_RD_RECV;
                    end else if (wd_expired) begin
                        state        <= S_DONE;
                        bus.done     <= 1'b1;
                        bus.done_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_RD_RECV: begin
                    // Assemble the final line from the incoming beat so fill_line
                    // only ever changes on a clean completion.
                    if (!resp) begin
                        state        <= S_DONE;
                        bus.done     <= 1'b1;
                        bus.done_err <= 1'b1;
                    end else if (last_beat) begin
                        state         <= S_DONE;
                        bus.done      <= 1'b1;
                        bus.fill_line <= {bus.d2_in, buf_line[LINE_BITS-1:DATA_BUS_SIZE]};
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_sequencer.sv
// Directed self-checking bench for cache_mem_sequencer with hand-computed
// expected bus traffic, latencies and received lines.
module tb_cache_mem_sequencer;
    import cache_bus2_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [127:0] line1;
    logic [127:0] line2;
    logic [15:0]  beats1 [8];
    logic [15:0]  beats2 [8];
    logic [127:0] exp1;
    logic [127:0] exp2;
    int           n;

    cache_mem_sequencer_if bus();

    cache_mem_sequencer #(.MEM_TIMEOUT(255)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish within bound");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_c2oe"}, 128'(bus.c2_oe), 128'(0));
        chk({tag, "_a2oe"}, 128'(bus.a2_oe), 128'(0));
        chk({tag, "_d2oe"}, 128'(bus.d2_oe), 128'(0));
    endtask

    initial begin
        line1 = 128'h0F0E0D0C0B0A09080706050403020100;
        line2 = 128'hFFEEDDCCBBAA99887766554433221100;
        beats1 = '{16'hBBAA, 16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0, 16'h0F1E, 16'h2D3C, 16'h4B5A};
        beats2 = '{16'h5A5A, 16'hC3C3, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC};
        exp1 = '0;
        exp2 = '0;
        for (int k = 0; k < 8; k++) begin
            exp1[16*k +: 16] = beats1[k];
            exp2[16*k +: 16] = beats2[k];
        end

        // Reset state
        RESET = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = 2'b00;
        bus.req_wb_addr = '0; bus.req_fill_addr = '0; bus.req_wb_line = '0;
        bus.c2_in = 2'd0; bus.d2_in = '0;
        repeat (2) step();
        chk_off("rst");
        chk("rst_c2out", 128'(bus.c2_out), 128'(0));
        chk("rst_ready", 128'(bus.req_ready), 128'(1));
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_fill", bus.fill_line, 128'(0));
        RESET = 1'b0;
        step();

        // Write-back: 8 beats, then 5 silent wait cycles, then RESPONSE
        chk("wb_ready_pre", 128'(bus.req_ready), 128'(1));
        bus.req_valid = 1'b1; bus.req_op = 2'b01;
        bus.req_wb_addr = 14'h0A5; bus.req_fill_addr = 14'h000; bus.req_wb_line = line1;
        step();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("wb_c2oe", 128'(bus.c2_oe), 128'(1));
            chk("wb_a2oe", 128'(bus.a2_oe), 128'(1));
            chk("wb_d2oe", 128'(bus.d2_oe), 128'(1));
            chk("wb_c2", 128'(bus.c2_out), 128'(3));
            chk("wb_a2", 128'(bus.a2_out), 128'(14'h0A5));
            chk("wb_d2", 128'(bus.d2_out), 128'({8'(2*k+1), 8'(2*k)}));
            chk("wb_ready", 128'(bus.req_ready), 128'(0));
            step();
        end
        chk_off("wb_wait");
        for (int k = 0; k < 5; k++) begin
            chk("wb_wait_done", 128'(bus.done), 128'(0));
            step();
        end
        bus.c2_in = 2'd1;
        step();
        bus.c2_in = 2'd0;
        chk("wb_done", 128'(bus.done), 128'(1));
        chk("wb_err", 128'(bus.done_err), 128'(0));
        chk("wb_ready_done", 128'(bus.req_ready), 128'(0));
        step();
        chk("wb_done_clr", 128'(bus.done), 128'(0));
        chk("wb_ready_post", 128'(bus.req_ready), 128'(1));

        // Fill: response on first wait cycle, 10-cycle latency
        bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_fill_addr = 14'h123;
        step();
        bus.req_valid = 1'b0;
        chk("fill_c2", 128'(bus.c2_out), 128'(2));
        chk("fill_a2", 128'(bus.a2_out), 128'(14'h123));
        chk("fill_c2oe", 128'(bus.c2_oe), 128'(1));
        chk("fill_a2oe", 128'(bus.a2_oe), 128'(1));
        chk("fill_d2oe", 128'(bus.d2_oe), 128'(0));
        step();
        chk_off("fill_wait");
        bus.c2_in = 2'd1; bus.d2_in = beats1[0];
        step();
        for (int k = 1; k < 8; k++) begin
            bus.c2_in = 2'd1; bus.d2_in = beats1[k];
            chk("fill_recv_done", 128'(bus.done), 128'(0));
            step();
        end
        bus.c2_in = 2'd0; bus.d2_in = '0;
        chk("fill_done", 128'(bus.done), 128'(1));
        chk("fill_err", 128'(bus.done_err), 128'(0));
        chk("fill_byte0", 128'(bus.fill_line[7:0]), 128'(8'hAA));
        chk("fill_byte1", 128'(bus.fill_line[15:8]), 128'(8'hBB));
        chk("fill_line", bus.fill_line, exp1);
        step();
        chk("fill_done_clr", 128'(bus.done), 128'(0));

        // Write-back then fill: 20-cycle latency, one TURN cycle, single done
        bus.req_valid = 1'b1; bus.req_op = 2'b11;
        bus.req_wb_addr = 14'h3FFF; bus.req_fill_addr = 14'h0001; bus.req_wb_line = line2;
        step();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("wbf_c2", 128'(bus.c2_out), 128'(3));
            chk("wbf_a2", 128'(bus.a2_out), 128'(14'h3FFF));
            chk("wbf_d2", 128'(bus.d2_out), 128'({8'((2*k+1)*17), 8'(2*k*17)}));
            step();
        end
        chk_off("wbf_wait");
        bus.c2_in = 2'd1;
        step();
        chk_off("wbf_turn");
        chk("wbf_turn_done", 128'(bus.done), 128'(0));
        chk("wbf_turn_c2", 128'(bus.c2_out), 128'(0));
        step();
        bus.c2_in = 2'd0;
        chk("wbf_rd_c2", 128'(bus.c2_out), 128'(2));
        chk("wbf_rd_a2", 128'(bus.a2_out), 128'(14'h0001));
        chk("wbf_rd_c2oe", 128'(bus.c2_oe), 128'(1));
        chk("wbf_rd_d2oe", 128'(bus.d2_oe), 128'(0));
        chk("wbf_rd_done", 128'(bus.done), 128'(0));
        step();
        for (int k = 0; k < 8; k++) begin
            bus.c2_in = 2'd1; bus.d2_in = beats2[k];
            chk("wbf_recv_done", 128'(bus.done), 128'(0));
            step();
        end
        bus.c2_in = 2'd0; bus.d2_in = '0;
        chk("wbf_done", 128'(bus.done), 128'(1));
        chk("wbf_err", 128'(bus.done_err), 128'(0));
        chk("wbf_line", bus.fill_line, exp2);
        step();
        chk("wbf_single_done", 128'(bus.done), 128'(0));

        // Timeout: silent memory, 255 wait cycles, fill_line preserved
        bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_fill_addr = 14'h055;
        step();
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("to_latency", 128'(n), 128'(256));
        chk("to_done", 128'(bus.done), 128'(1));
        chk("to_err", 128'(bus.done_err), 128'(1));
        chk("to_fill_kept", bus.fill_line, exp2);
        step();
        chk("to_done_clr", 128'(bus.done), 128'(0));
        chk("to_ready", 128'(bus.req_ready), 128'(1));

        // Protocol error: RESPONSE drops at beat 4
        bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_fill_addr = 14'h2AA;
        step();
        bus.req_valid = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            bus.c2_in = 2'd1; bus.d2_in = beats1[k];
            step();
        end
        bus.c2_in = 2'd0;
        chk("perr_pending", 128'(bus.done), 128'(0));
        step();
        chk("perr_done", 128'(bus.done), 128'(1));
        chk("perr_err", 128'(bus.done_err), 128'(1));
        chk("perr_fill_kept", bus.fill_line, exp2);
        step();

        // Opcode 00 is ignored
        bus.req_valid = 1'b1; bus.req_op = 2'b00;
        step();
        bus.req_valid = 1'b0;
        chk("nop_ready", 128'(bus.req_ready), 128'(1));
        chk_off("nop");
        step();
        chk("nop_done", 128'(bus.done), 128'(0));

        // Reset during write-back beat 3, then a normal fill
        bus.req_valid = 1'b1; bus.req_op = 2'b01;
        bus.req_wb_addr = 14'h0A5; bus.req_wb_line = line1;
        step();
        bus.req_valid = 1'b0;
        repeat (3) step();
        chk("rmid_beat3", 128'(bus.d2_out), 128'(16'h0706));
        #2;
        RESET = 1'b1;
        #1;
        chk_off("rmid");
        chk("rmid_c2out", 128'(bus.c2_out), 128'(0));
        chk("rmid_ready", 128'(bus.req_ready), 128'(1));
        chk("rmid_done", 128'(bus.done), 128'(0));
        step();
        RESET = 1'b0;
        step();
        chk("rmid_post_done", 128'(bus.done), 128'(0));
        chk("rmid_post_fill", bus.fill_line, 128'(0));
        bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_fill_addr = 14'h0F0;
        step();
        bus.req_valid = 1'b0;
        chk("rnew_a2", 128'(bus.a2_out), 128'(14'h0F0));
        step();
        for (int k = 0; k < 8; k++) begin
            bus.c2_in = 2'd1; bus.d2_in = beats1[k];
            step();
        end
        bus.c2_in = 2'd0;
        chk("rnew_done", 128'(bus.done), 128'(1));
        chk("rnew_err", 128'(bus.done_err), 128'(0));
        chk("rnew_line", bus.fill_line, exp1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
